lfsr_cam_param: RTL and testbench

Parametrised LFSR-addressed associative memory, successor to the fixed 8-bit/255-entry LFSR CAM. Entries are written sequentially at addresses produced by a maximal-length LFSR. A search replays the same LFSR sequence and compares one entry per cycle, reporting the LFSR address of the match. Adds generic data and address widths, a single clock, and explicit not-found reporting. Multi-match continuation (`Next_Ext`) returns every matching entry in write order.

---
 rtl/lfsr_cam_param.sv | 165 ++++++++++++++++
 tb/tb_lfsr_cam_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_cam_param.sv
// LFSR-addressed associative memory: sequential writes at LFSR addresses, one-entry-per-cycle search.
// Optional ternary compare with a per-search don't-care mask when LFSR_CAM_MASK_EN is defined.
module lfsr_cam_param #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] LFSR_TAPS = ADDR_W'(8'hB8),
    parameter logic [ADDR_W-1:0] LFSR_SEED = ADDR_W'(1)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Data_in,
`ifdef LFSR_CAM_MASK_EN
    input  logic [DATA_W-1:0] Mask_in,
`endif
    input  logic              WR_Ext,
    input  logic              RD_Ext,
    input  logic              Next_Ext,
    output logic [ADDR_W-1:0] Address_out,
    output logic              Compare_Found_Out,
    output logic              Not_Found_Out,
    output logic              Busy,
    output logic              Full,
    output logic [ADDR_W-1:0] Fill_Count
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CAPACITY = '1;
    localparam logic [ADDR_W-1:0] CAP_M1   = CAPACITY - 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] sp;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] key_q;
`ifdef LFSR_CAM_MASK_EN
    logic [DATA_W-1:0] mask_q;
`endif
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic accepting;
    logic start_search;
    logic do_write;
    logic scan_done;
    logic scan_hit;

    function automatic logic [ADDR_W-1:0] lfsr_step(input logic [ADDR_W-1:0] s);
        return {s[ADDR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

`ifdef LFSR_CAM_MASK_EN
    function automatic logic entry_match(input logic [DATA_W-1:0] word,
                                         input logic [DATA_W-1:0] key,
                                         input logic [DATA_W-1:0] mask);
        return ((word ^ key) & ~mask) == '0;
    endfunction
`else
    function automatic logic entry_match(input logic [DATA_W-1:0] word,
                                         input logic [DATA_W-1:0] key);
        return word == key;
    endfunction
`endif

    // Commands are only honoured outside SCAN; a read or continue request shadows a write.
    assign accepting    = (state != SCAN);
    assign start_search = accepting && RD_Ext;
    assign do_write     = accepting && WR_Ext && !RD_Ext && !Next_Ext && !Full;
    assign scan_done    = (state == SCAN) && (cnt == Fill_Count);
`ifdef LFSR_CAM_MASK_EN
    assign scan_hit     = (state == SCAN) && !scan_done && entry_match(mem[sp], key_q, mask_q);
`else
    assign scan_hit     = (state == SCAN) && !scan_done && entry_match(mem[sp], key_q);
`endif

    // Storage and search key are data: never reset, validity is tracked by Fill_Count.
    always_ff @(posedge Clock) begin
        if (do_write) begin
            mem[wp] <= Data_in;
        end
        if (start_search) begin
            key_q  <= Data_in;
`ifdef LFSR_CAM_MASK_EN
            mask_q <= Mask_in;
`endif
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state             <= IDLE;
            wp                <= LFSR_SEED;
            sp                <= LFSR_SEED;
            cnt               <= '0;
            Fill_Count        <= '0;
            Full              <= 1'b0;
            Address_out       <= '0;
            Compare_Found_Out <= 1'b0;
            Not_Found_Out     <= 1'b0;
            Busy              <= 1'b0;
        end else begin
            Compare_Found_Out <= 1'b0;
            Not_Found_Out     <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_search) begin
                        state <= SCAN;
                        sp    <= LFSR_SEED;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                    end
                end

                SCAN: begin
                    if (scan_done) begin
                        Not_Found_Out <= 1'b1;
                        state         <= IDLE;
                        Busy          <= 1'b0;
                    end else begin
                        sp  <= lfsr_step(sp);
                        cnt <= cnt + 1'b1;
                        if (scan_hit) begin
                            Address_out       <= sp;
                            Compare_Found_Out <= 1'b1;
                            state             <= PAUSE;
                            Busy              <= 1'b0;
                        end
                    end
                end

                PAUSE: begin
                    if (start_search) begin
                        state <= SCAN;
                        sp    <= LFSR_SEED;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                    end else if (Next_Ext) begin
                        state <= SCAN;
                        Busy  <= 1'b1;
                    end else if (do_write) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase

            // do_write excludes SCAN and any read/continue request, so it never races the case above.
            if (do_write) begin
                wp         <= lfsr_step(wp);
                Fill_Count <= Fill_Count + 1'b1;
                Full       <= (Fill_Count == CAP_M1);
            end
        end
    end

endmodule

// File: tb/tb_lfsr_cam_param.sv
// Self-checking bench for lfsr_cam_param (8-bit data/address); mask tests under LFSR_CAM_MASK_EN.
module tb_lfsr_cam_param;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] Data_in;
    logic [7:0] mask_v;
    logic       WR_Ext;
    logic       RD_Ext;
    logic       Next_Ext;
    logic [7:0] Address_out;
    logic       Compare_Found_Out;
    logic       Not_Found_Out;
    logic       Busy;
    logic       Full;
    logic [7:0] Fill_Count;

    always #5 Clock = ~Clock;

    lfsr_cam_param #(
        .DATA_W(8),
        .ADDR_W(8)
    ) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .Data_in          (Data_in),
`ifdef LFSR_CAM_MASK_EN
        .Mask_in          (mask_v),
`endif
        .WR_Ext           (WR_Ext),
        .RD_Ext           (RD_Ext),
        .Next_Ext         (Next_Ext),
        .Address_out      (Address_out),
        .Compare_Found_Out(Compare_Found_Out),
        .Not_Found_Out    (Not_Found_Out),
        .Busy             (Busy),
        .Full             (Full),
        .Fill_Count       (Fill_Count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: entries in write order; ordinal i lives at LFSR address tab[i].
    int tab [0:255];
    int mdata[$];
    int mpos;
    int maddr;
    bit last_hit;

    function automatic int lfsr_next(input int s);
        int fb;
        fb = 0;
        for (int b = 0; b < 8; b++) begin
            if ((((s & 'hB8) >> b) & 1) != 0) fb = fb ^ 1;
        end
        return ((s << 1) | fb) & 'hFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        mdata.delete();
        mpos     = 0;
        maddr    = 0;
        last_hit = 1'b0;
    endtask

    task automatic wr(input int v);
        @(negedge Clock);
        Data_in = 8'(v);
        WR_Ext  = 1'b1;
        @(negedge Clock);
        WR_Ext  = 1'b0;
        if (mdata.size() < 255) mdata.push_back(v);
    endtask

    task automatic search(input bit is_next, input int key, input int mask, input string tag);
        int start;
        int exp_lat;
        int lat;
        bit exp_hit;
        start   = is_next ? mpos : 0;
        exp_hit = 1'b0;
        exp_lat = mdata.size() - start + 1;
        for (int j = start; j < mdata.size(); j++) begin
            if ((((mdata[j] ^ key) & ~mask) & 'hFF) == 0) begin
                exp_hit = 1'b1;
                exp_lat = j - start + 1;
                maddr   = tab[j];
                mpos    = j + 1;
                break;
            end
        end
        last_hit = exp_hit;

        @(negedge Clock);
        Data_in  = 8'(key);
        mask_v   = 8'(mask);
        RD_Ext   = !is_next;
        Next_Ext = is_next;
        @(negedge Clock);
        RD_Ext   = 1'b0;
        Next_Ext = 1'b0;
        chk({tag, ".busy"}, Busy, 1);
        lat = 0;
        do begin
            @(negedge Clock);
            lat++;
        end while (!Compare_Found_Out && !Not_Found_Out && lat < 300);
        chk({tag, ".found"}, Compare_Found_Out, exp_hit);
        chk({tag, ".notfound"}, Not_Found_Out, !exp_hit);
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".addr"}, Address_out, maddr);
        @(negedge Clock);
        chk({tag, ".pulse_end"}, {Compare_Found_Out, Not_Found_Out, Busy}, 0);
    endtask

    int order [0:254];
    int tmp;
    int k;

    initial begin
        Reset    = 1'b1;
        Data_in  = '0;
        mask_v   = '0;
        WR_Ext   = 1'b0;
        RD_Ext   = 1'b0;
        Next_Ext = 1'b0;
        tab[0] = 1;
        for (int i = 1; i < 256; i++) tab[i] = lfsr_next(tab[i-1]);

        do_reset();
        chk("rst.addr", Address_out, 0);
        chk("rst.found", Compare_Found_Out, 0);
        chk("rst.notfound", Not_Found_Out, 0);
        chk("rst.busy", Busy, 0);
        chk("rst.full", Full, 0);
        chk("rst.fill", Fill_Count, 0);

        search(1'b0, 'h12, 0, "empty");

        for (int v = 1; v <= 255; v++) wr(v);
        chk("fill.full", Full, 1);
        chk("fill.count", Fill_Count, 255);
        wr('h77);
        chk("drop.full", Full, 1);
        chk("drop.count", Fill_Count, 255);
        search(1'b0, 'h01, 0, "drop.first");
        search(1'b0, 'h77, 0, "drop.absent");

        for (int i = 0; i < 255; i++) order[i] = i + 1;
        for (int i = 254; i > 0; i--) begin
            k = $urandom_range(0, i);
            tmp = order[i];
            order[i] = order[k];
            order[k] = tmp;
        end
        for (int i = 0; i < 255; i++) search(1'b0, order[i], 0, "exh");

        do_reset();
        wr('h5A);
        wr('h11);
        wr('h5A);
        search(1'b0, 'h5A, 0, "dup.first");
        chk("dup.first_addr", Address_out, 'h01);
        search(1'b1, 'h5A, 0, "dup.second");
        search(1'b1, 'h5A, 0, "dup.exhausted");
        search(1'b0, 'hAA, 0, "miss3");

        do_reset();
        k = $urandom_range(10, 40);
        for (int i = 0; i < k; i++) wr($urandom_range(0, 7));
        for (int t = 0; t < 12; t++) begin
            tmp = $urandom_range(0, 7);
            search(1'b0, tmp, 0, "rnd");
            while (last_hit && $urandom_range(0, 3) != 0) search(1'b1, tmp, 0, "rnd.next");
            if ($urandom_range(0, 1) != 0) wr($urandom_range(0, 7));
        end

        do_reset();
        for (int i = 0; i < 200; i++) wr($urandom_range(0, 'h7F));
        @(negedge Clock);
        Data_in = 8'hFF;
        RD_Ext  = 1'b1;
        @(negedge Clock);
        RD_Ext  = 1'b0;
        chk("midrst.busy_e0", Busy, 1);
        @(negedge Clock);
        chk("midrst.e1", {Compare_Found_Out, Not_Found_Out}, 0);
        @(negedge Clock);
        chk("midrst.e2", {Compare_Found_Out, Not_Found_Out}, 0);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        mdata.delete();
        mpos  = 0;
        maddr = 0;
        chk("midrst.busy", Busy, 0);
        chk("midrst.fill", Fill_Count, 0);
        chk("midrst.pulses", {Compare_Found_Out, Not_Found_Out}, 0);
        @(negedge Clock);
        chk("midrst.idle", {Compare_Found_Out, Not_Found_Out, Busy}, 0);
        search(1'b0, 'hFF, 0, "midrst.after");

`ifdef LFSR_CAM_MASK_EN
        do_reset();
        wr('h3C);
        search(1'b0, 'h30, 'h0F, "mask.hit");
        search(1'b0, 'h30, 'h00, "mask.miss");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit reached");
    end

endmodule
